// File: rtl/trap_controller.sv
// Trap sequencer into the CSR unit: detects exceptions, interrupts and mret, then redirects fetch.
// Latency: trap request at N+1 and redirect at N+2; mret redirect at N+1. No backpressure: it ignores all events while it sequences.
module trap_controller #(
    parameter int XLEN        = 32,
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instValid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic            fetchMisaligned_i,
    input  logic            illegalInstr_i,
    input  logic            ebreak_i,
    input  logic            ecall_i,
    input  logic            loadMisaligned_i,
    input  logic            storeMisaligned_i,
    input  logic [XLEN-1:0] memAddr_i,
    input  logic            mret_i,
    input  logic            mtimeExc_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic            excRequest_o,
    output logic [XLEN-1:0] excCause_o,
    output logic [XLEN-1:0] trapInfo_o,
    output logic [XLEN-1:0] excPc_o,
    output logic            mretDone_o,
    output logic            kill_o,
    output logic            stall_o,
    output logic            pcRedirect_o,
    output logic [XLEN-1:0] pcTarget_o
);

    typedef enum logic [1:0] {IDLE, TRAP_REQ, TRAP_JUMP, MRET_JUMP} state_e;

    localparam logic [XLEN-1:0] CAUSE_TIMER = {1'b1, {(XLEN-5){1'b0}}, 4'd7};

    state_e          state_q, state_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] info_q, info_d;
    logic [XLEN-1:0] epc_q, epc_d;

    logic            trap_det;
    logic            mret_det;
    logic [XLEN-1:0] det_cause;
    logic [XLEN-1:0] det_info;
    logic [XLEN-1:0] vec_base;

    // Priority encoder; only evaluated while idle with a valid instruction.
    always_comb begin
        trap_det  = 1'b0;
        mret_det  = 1'b0;
        det_cause = '0;
        det_info  = '0;
        if (state_q == IDLE && instValid_i) begin
            trap_det = 1'b1;
            if (mtimeExc_i) begin
                det_cause = CAUSE_TIMER;
            end else if (fetchMisaligned_i) begin
                det_cause = XLEN'(0);
                det_info  = memAddr_i;
            end else if (illegalInstr_i) begin
                det_cause = XLEN'(2);
                det_info  = instr_i;
            end else if (ebreak_i) begin
                det_cause = XLEN'(3);
                det_info  = pc_i;
            end else if (ecall_i) begin
                det_cause = XLEN'(11);
            end else if (loadMisaligned_i) begin
                det_cause = XLEN'(4);
                det_info  = memAddr_i;
            end else if (storeMisaligned_i) begin
                det_cause = XLEN'(6);
                det_info  = memAddr_i;
            end else begin
                trap_det = 1'b0;
                mret_det = mret_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cause_q <= '0;
            info_q  <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            info_q  <= info_d;
            epc_q   <= epc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        info_d  = info_q;
        epc_d   = epc_q;
        case (state_q)
            IDLE: begin
                if (trap_det) begin
                    state_d = TRAP_REQ;
                    cause_d = det_cause;
                    info_d  = det_info;
                    epc_d   = pc_i;
                end else if (mret_det) begin
                    state_d = MRET_JUMP;
                end
            end
            TRAP_REQ:  state_d = TRAP_JUMP;
            TRAP_JUMP: state_d = IDLE;
            MRET_JUMP: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Vectored mode applies only to interrupts with mtvec mode 01; mode 1x falls back to direct.
    assign vec_base = {mtvec_i[XLEN-1:2], 2'b00};

    always_comb begin
        excRequest_o = 1'b0;
        excCause_o   = '0;
        trapInfo_o   = '0;
        excPc_o      = '0;
        mretDone_o   = 1'b0;
        kill_o       = 1'b0;
        stall_o      = 1'b0;
        pcRedirect_o = 1'b0;
        pcTarget_o   = '0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    kill_o  = trap_det;
                    stall_o = trap_det | mret_det;
                end
                TRAP_REQ: begin
                    excRequest_o = 1'b1;
                    excCause_o   = cause_q;
                    trapInfo_o   = info_q;
                    excPc_o      = epc_q;
                    stall_o      = 1'b1;
                    kill_o       = 1'b1;
                end
                TRAP_JUMP: begin
                    pcRedirect_o = 1'b1;
                    kill_o       = 1'b1;
                    if (VECTORED_EN && mtvec_i[1:0] == 2'b01 && cause_q[XLEN-1])
                        pcTarget_o = vec_base + XLEN'({cause_q[4:0], 2'b00});
                    else
                        pcTarget_o = vec_base;
                end
                MRET_JUMP: begin
                    pcRedirect_o = 1'b1;
                    pcTarget_o   = mepc_i;
                    mretDone_o   = 1'b1;
                    kill_o       = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
